cve2_register_file_mp: RTL and testbench

Parametrised flip-flop register file for cve2: 31 (or 15 with RV32E) registers of DataWidth bits, x0 hard-wired to WordZeroVal, NumReadPorts combinational read ports and two write ports. Port A is the in-order ALU/ID writeback. Port B is the out-of-order LSU writeback for long-latency loads. A per-register pending scoreboard records reserved destinations and reports busy source registers to the ID stage for hazard stalls.

---
 rtl/cve2_register_file_mp_if.sv | 32 +++
 rtl/cve2_register_file_mp.sv | 112 +++++++++++
 tb/tb_cve2_register_file_mp.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cve2_register_file_mp_if.sv
// Bus bundle for cve2_register_file_mp: read ports, the two writeback ports,
// reservation strobe and scoreboard status.
interface cve2_register_file_mp_if #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NumReadPorts = 2
);
  logic [NumReadPorts-1:0][4:0]           raddr_i;
  logic [NumReadPorts-1:0][DataWidth-1:0] rdata_o;
  logic [NumReadPorts-1:0]                rbusy_o;
  logic [4:0]                             waddr_a_i;
  logic [DataWidth-1:0]                   wdata_a_i;
  logic                                   we_a_i;
  logic [4:0]                             waddr_b_i;
  logic [DataWidth-1:0]                   wdata_b_i;
  logic                                   we_b_i;
  logic [4:0]                             rsv_addr_i;
  logic                                   rsv_i;
  logic                                   busy_any_o;
  logic                                   err_o;

  modport slave (
    input  raddr_i, waddr_a_i, wdata_a_i, we_a_i, waddr_b_i, wdata_b_i, we_b_i,
           rsv_addr_i, rsv_i,
    output rdata_o, rbusy_o, busy_any_o, err_o
  );

  modport master (
    output raddr_i, waddr_a_i, wdata_a_i, we_a_i, waddr_b_i, wdata_b_i, we_b_i,
           rsv_addr_i, rsv_i,
    input  rdata_o, rbusy_o, busy_any_o, err_o
  );
endinterface

// File: rtl/cve2_register_file_mp.sv
// Flip-flop register file with in-order (A) and out-of-order LSU (B) write ports
// plus a pending scoreboard. Optional same-cycle forwarding: CVE2_RF_WB_BYPASS_EN.
module cve2_register_file_mp #(
  parameter bit                   RV32E        = 1'b0,
  parameter int unsigned          DataWidth    = 32,
  parameter logic [DataWidth-1:0] WordZeroVal  = '0,
  parameter int unsigned          NumReadPorts = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     test_en_i,
  cve2_register_file_mp_if.slave   rf
);
  localparam int unsigned NumWords = RV32E ? 16 : 32;
  localparam int unsigned AddrW    = RV32E ? 4 : 5;

  logic [AddrW-1:0] waddr_a, waddr_b, rsv_addr;
  assign waddr_a  = rf.waddr_a_i[AddrW-1:0];
  assign waddr_b  = rf.waddr_b_i[AddrW-1:0];
  assign rsv_addr = rf.rsv_addr_i[AddrW-1:0];

  logic [NumWords-1:1] we_a_dec, we_b_dec, rsv_dec;
  logic [NumWords-1:1] pending_q, pending_d;
  logic                err_q, err_d;
  logic [DataWidth-1:0] rf_q [NumWords-1:1];

  // Decode covers x1.. only, so x0 can never be written, reserved or flagged.
  always_comb begin
    we_a_dec = '0;
    we_b_dec = '0;
    rsv_dec  = '0;
    for (int i = 1; i < NumWords; i++) begin
      we_a_dec[i] = rf.we_a_i && (waddr_a == AddrW'(i));
      we_b_dec[i] = rf.we_b_i && (waddr_b == AddrW'(i));
      rsv_dec[i]  = rf.rsv_i  && (rsv_addr == AddrW'(i));
    end
  end

  // A fresh reservation outranks a same-cycle port B completion.
  assign pending_d = (pending_q & ~we_b_dec) | rsv_dec;

  assign err_d = (|(rsv_dec & pending_q & ~we_b_dec)) |
                 (|(we_b_dec & ~pending_q)) |
                 (|(we_a_dec & pending_q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NumWords; i++) begin
        rf_q[i] <= WordZeroVal;
      end
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 1; i < NumWords; i++) begin
        if (we_a_dec[i]) begin
          rf_q[i] <= rf.wdata_a_i;
        end else if (we_b_dec[i]) begin
          rf_q[i] <= rf.wdata_b_i;
        end
      end
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  logic [DataWidth-1:0] rf_full [NumWords];
  logic [NumWords-1:0]  pend_full;

  assign rf_full[0] = WordZeroVal;
  for (genvar i = 1; i < NumWords; i++) begin : g_full
    assign rf_full[i] = rf_q[i];
  end
  assign pend_full = {pending_q, 1'b0};

  for (genvar k = 0; k < NumReadPorts; k++) begin : g_rd
    logic [AddrW-1:0]     ra;
    logic [DataWidth-1:0] data;
    logic                 busy;
    logic                 unused_raddr_msb;

    assign ra               = rf.raddr_i[k][AddrW-1:0];
    assign unused_raddr_msb = rf.raddr_i[k][4];

    always_comb begin
      data = rf_full[ra];
      busy = pend_full[ra];
`ifdef CVE2_RF_WB_BYPASS_EN
      if (ra != '0) begin
        if (rf.we_b_i && (waddr_b == ra)) begin
          data = rf.wdata_b_i;
          if (!(rf.rsv_i && (rsv_addr == ra))) begin
            busy = 1'b0;
          end
        end
        if (rf.we_a_i && (waddr_a == ra)) begin
          data = rf.wdata_a_i;
        end
      end
`endif
    end

    assign rf.rdata_o[k] = data;
    assign rf.rbusy_o[k] = busy;
  end

  assign rf.busy_any_o = |pending_q;
  assign rf.err_o      = err_q;

  logic unused_sig;
  assign unused_sig = ^{test_en_i, rf.waddr_a_i[4], rf.waddr_b_i[4], rf.rsv_addr_i[4]};

endmodule

// File: tb/tb_cve2_register_file_mp.sv
// Directed bench for cve2_register_file_mp: default config plus an RV32E
// three-read-port instance, checked through an expectation queue.
module tb_cve2_register_file_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cve2_register_file_mp_if #(.DataWidth(32), .NumReadPorts(2)) rf0 ();
  cve2_register_file_mp_if #(.DataWidth(32), .NumReadPorts(3)) rf1 ();

  cve2_register_file_mp #(
    .RV32E(1'b0), .DataWidth(32), .NumReadPorts(2)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0), .rf(rf0)
  );

  cve2_register_file_mp #(
    .RV32E(1'b1), .DataWidth(32), .NumReadPorts(3)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0), .rf(rf1)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=0x%08h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle();
    rf0.we_a_i = 1'b0; rf0.we_b_i = 1'b0; rf0.rsv_i = 1'b0;
    rf0.waddr_a_i = '0; rf0.waddr_b_i = '0; rf0.rsv_addr_i = '0;
    rf0.wdata_a_i = '0; rf0.wdata_b_i = '0;
    rf1.we_a_i = 1'b0; rf1.we_b_i = 1'b0; rf1.rsv_i = 1'b0;
    rf1.waddr_a_i = '0; rf1.waddr_b_i = '0; rf1.rsv_addr_i = '0;
    rf1.wdata_a_i = '0; rf1.wdata_b_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rf0.raddr_i[0] = 5'd5; rf0.raddr_i[1] = 5'd7;
    rf1.raddr_i[0] = 5'd1; rf1.raddr_i[1] = 5'd2; rf1.raddr_i[2] = 5'd0;
    #12;
    expect_val("rst_rdata0", 32'h0);  check(rf0.rdata_o[0]);
    expect_val("rst_rbusy", 32'h0);   check(32'(rf0.rbusy_o));
    expect_val("rst_busy_any", 32'h0); check(32'(rf0.busy_any_o));
    expect_val("rst_err", 32'h0);     check(32'(rf0.err_o));
    rst_n = 1'b1;
    step();

    // x5 via port A, then x0 write attempt
    rf0.we_a_i = 1'b1; rf0.waddr_a_i = 5'd5; rf0.wdata_a_i = 32'hDEADBEEF;
    expect_val("x5_read", 32'hDEADBEEF);
    expect_val("x0_read", 32'h0);
    step();
    idle();
    rf0.raddr_i[0] = 5'd5; rf0.raddr_i[1] = 5'd0;
    #1;
    check(rf0.rdata_o[0]);
    check(rf0.rdata_o[1]);
    rf0.we_a_i = 1'b1; rf0.waddr_a_i = 5'd0; rf0.wdata_a_i = 32'hFFFFFFFF;
    expect_val("x0_after_write", 32'h0);
    step();
    idle();
    #1;
    check(rf0.rdata_o[1]);

    // reserve x7, complete on port B
    rf0.rsv_i = 1'b1; rf0.rsv_addr_i = 5'd7;
    expect_val("x7_rbusy", 32'h1);
    expect_val("x7_busy_any", 32'h1);
    step();
    idle();
    rf0.raddr_i[0] = 5'd7;
    #1;
    check(32'(rf0.rbusy_o[0]));
    check(32'(rf0.busy_any_o));
    rf0.we_b_i = 1'b1; rf0.waddr_b_i = 5'd7; rf0.wdata_b_i = 32'h1234;
`ifdef CVE2_RF_WB_BYPASS_EN
    expect_val("x7_bypass_data", 32'h1234);
    expect_val("x7_bypass_rbusy", 32'h0);
`else
    expect_val("x7_wb_cycle_data", 32'h0);
    expect_val("x7_wb_cycle_rbusy", 32'h1);
`endif
    #1;
    check(rf0.rdata_o[0]);
    check(32'(rf0.rbusy_o[0]));
    expect_val("x7_after_data", 32'h1234);
    expect_val("x7_after_rbusy", 32'h0);
    expect_val("x7_after_busy_any", 32'h0);
    expect_val("x7_after_err", 32'h0);
    step();
    idle();
    #1;
    check(rf0.rdata_o[0]);
    check(32'(rf0.rbusy_o[0]));
    check(32'(rf0.busy_any_o));
    check(32'(rf0.err_o));

    // A and B both write pending x3: A data wins, pending cleared
    rf0.rsv_i = 1'b1; rf0.rsv_addr_i = 5'd3;
    step();
    idle();
    rf0.we_a_i = 1'b1; rf0.waddr_a_i = 5'd3; rf0.wdata_a_i = 32'hA;
    rf0.we_b_i = 1'b1; rf0.waddr_b_i = 5'd3; rf0.wdata_b_i = 32'hB;
    expect_val("x3_dual_data", 32'hA);
    expect_val("x3_dual_rbusy", 32'h0);
    expect_val("x3_dual_busy_any", 32'h0);
    step();
    idle();
    rf0.raddr_i[0] = 5'd3;
    #1;
    check(rf0.rdata_o[0]);
    check(32'(rf0.rbusy_o[0]));
    check(32'(rf0.busy_any_o));
    step();

    // reservation beats same-cycle port B clear on x9
    rf0.rsv_i = 1'b1; rf0.rsv_addr_i = 5'd9;
    step();
    rf0.we_b_i = 1'b1; rf0.waddr_b_i = 5'd9; rf0.wdata_b_i = 32'h99;
    expect_val("x9_still_busy", 32'h1);
    expect_val("x9_no_err", 32'h0);
    expect_val("x9_data", 32'h99);
    step();
    idle();
    rf0.raddr_i[0] = 5'd9;
    #1;
    check(32'(rf0.rbusy_o[0]));
    check(32'(rf0.err_o));
    check(rf0.rdata_o[0]);
    rf0.rsv_i = 1'b1; rf0.rsv_addr_i = 5'd9;
    expect_val("x9_rsv_twice_err", 32'h1);
    step();
    idle();
    #1;
    check(32'(rf0.err_o));
    expect_val("err_pulse_end", 32'h0);
    step();
    check(32'(rf0.err_o));

    // port B to a non-pending register
    rf0.we_b_i = 1'b1; rf0.waddr_b_i = 5'd4; rf0.wdata_b_i = 32'h44;
    expect_val("x4_b_err", 32'h1);
    expect_val("x4_b_data", 32'h44);
    step();
    idle();
    rf0.raddr_i[0] = 5'd4;
    #1;
    check(32'(rf0.err_o));
    check(rf0.rdata_o[0]);
    expect_val("x4_err_end", 32'h0);
    step();
    check(32'(rf0.err_o));

    // asynchronous reset while reservations outstanding
    rf0.rsv_i = 1'b1; rf0.rsv_addr_i = 5'd11;
    step();
    idle();
    rf0.raddr_i[0] = 5'd5; rf0.raddr_i[1] = 5'd11;
    expect_val("pre_rst_x11_busy", 32'h1);
    expect_val("pre_rst_x5", 32'hDEADBEEF);
    #1;
    check(32'(rf0.rbusy_o[1]));
    check(rf0.rdata_o[0]);
    #1;
    rst_n = 1'b0;
    expect_val("mid_rst_busy_any", 32'h0);
    expect_val("mid_rst_x5", 32'h0);
    expect_val("mid_rst_x11_busy", 32'h0);
    #1;
    check(32'(rf0.busy_any_o));
    check(rf0.rdata_o[0]);
    check(32'(rf0.rbusy_o[1]));
    #2;
    rst_n = 1'b1;
    step();

    // RV32E, three read ports: bit 4 of addresses is ignored
    rf1.we_a_i = 1'b1; rf1.waddr_a_i = 5'd17; rf1.wdata_a_i = 32'h11;
    step();
    idle();
    rf1.we_a_i = 1'b1; rf1.waddr_a_i = 5'd2; rf1.wdata_a_i = 32'h22;
    rf1.rsv_i = 1'b1; rf1.rsv_addr_i = 5'd19;
    expect_val("e_x1", 32'h11);
    expect_val("e_x2", 32'h22);
    expect_val("e_x0", 32'h0);
    step();
    idle();
    rf1.raddr_i[0] = 5'd1; rf1.raddr_i[1] = 5'd2; rf1.raddr_i[2] = 5'd0;
    #1;
    check(rf1.rdata_o[0]);
    check(rf1.rdata_o[1]);
    check(rf1.rdata_o[2]);
    rf1.raddr_i[2] = 5'd3;
    expect_val("e_x3_busy", 32'h1);
    expect_val("e_x1_not_busy", 32'h0);
    #1;
    check(32'(rf1.rbusy_o[2]));
    check(32'(rf1.rbusy_o[0]));

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
